// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encodings, FSM states and
// the initial-carry rule used when an operation is loaded.
package alu_pkg;

  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

  // Logic-mode select codes
  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_INV  = 2'b01;
  localparam logic [1:0] SEL_XOR  = 2'b10;
  localparam logic [1:0] SEL_XNOR = 2'b11;

  // Arithmetic-mode select codes
  localparam logic [1:0] SEL_ADD  = 2'b00;
  localparam logic [1:0] SEL_NADD = 2'b01;
  localparam logic [1:0] SEL_SUB  = 2'b10;
  localparam logic [1:0] SEL_RSUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Both subtractions use two's complement, so they start with a carry of one.
  function automatic logic init_carry(input logic mode, input logic [1:0] select);
    return (mode == MODE_ARITH) && (select == SEL_SUB || select == SEL_RSUB);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU slice with carry in/out; one bit of the serial
// datapath is resolved through this slice every RUN cycle.
module alu_slice
  import alu_pkg::*;
(
  input  logic       mode,
  input  logic [1:0] select,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  output logic       res,
  output logic       cout
);

  logic op_a;
  logic op_b;

  always_comb begin
    op_a = a;
    op_b = b;
    res  = 1'b0;
    cout = 1'b0;
    if (mode == MODE_ARITH) begin
      op_a = (select == SEL_NADD || select == SEL_RSUB) ? ~a : a;
      op_b = (select == SEL_SUB) ? ~b : b;
      res  = op_a ^ op_b ^ cin;
      cout = (op_a & op_b) | (cin & (op_a ^ op_b));
    end else begin
      case (select)
        SEL_PASS: res = a;
        SEL_INV:  res = ~a;
        SEL_XOR:  res = a ^ b;
        SEL_XNOR: res = ~(a ^ b);
        default:  res = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial N-bit ALU: operands are loaded on start and processed LSB-first
// through one alu_slice, with a start/busy/done handshake around the result.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_final;
  logic [CW-1:0]    cnt;
  logic             mode_q;
  logic [1:0]       select_q;
  logic             carry_q;
  logic             slice_res;
  logic             slice_cout;
  logic             load;
  logic             step;
  logic             last;

  alu_slice u_slice (
    .mode   (mode_q),
    .select (select_q),
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .cin    (carry_q),
    .res    (slice_res),
    .cout   (slice_cout)
  );

  assign last      = (cnt == CW'(WIDTH - 1));
  assign res_final = {slice_res, res_sh[WIDTH-1:1]};
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The completed result is assembled from the partial shift register plus
  // the bit being produced this cycle, so Output updates on the last RUN edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      mode_q   <= MODE_LOGIC;
      select_q <= SEL_PASS;
      carry_q  <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
    end else if (load) begin
      a_sh     <= a;
      b_sh     <= b;
      mode_q   <= mode;
      select_q <= select;
      carry_q  <= init_carry(mode, select);
      cnt      <= '0;
    end else if (step) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= res_final;
      carry_q <= slice_cout;
      if (last) begin
        result <= res_final;
        carry  <= (mode_q == MODE_ARITH) ? slice_cout : 1'b0;
        zero   <= (res_final == '0);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_serial.md
# alu_serial

Parametrised N-bit bit-serial ALU, successor to the team's 1-bit combinational ALU. Operands are loaded in one cycle and then processed LSB-first, one bit per clock, through a single 1-bit ALU slice with a registered carry. The result and flags are presented with a Start/Busy/Done handshake. The block is intended as the arithmetic/logic unit of small multi-cycle datapaths where area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH ≥ 2
- Clock  input  1  single clock; all state changes on the rising edge
- Reset  input  1  synchronous, active-high; clears all state on the next rising edge
- Start  input  1  request; sampled only in IDLE or DONE
- Mode  input  1  0 = logic, 1 = arithmetic; captured with Start
- Select  input  2  operation select; captured with Start
- A  input  WIDTH  operand A; captured with Start
- B  input  WIDTH  operand B; captured with Start
- Busy  output  1  high while in RUN
- Done  output  1  one-cycle pulse when Output, Carry and Zero are updated
- Output  output  WIDTH  result register; holds until the next completion
- Carry  output  1  final carry-out for arithmetic ops; 0 for logic ops
- Zero  output  1  1 when the completed result is all zeros

## Operation
- Logic ops (Mode=0), per bit:
  - Select 00: A
  - Select 01: ~A
  - Select 10: A^B
  - Select 11: ~(A^B)
- Arithmetic ops (Mode=1), modulo 2^WIDTH:
  - Select 00: A+B, initial carry 0
  - Select 01: ~A+B, initial carry 0
  - Select 10: A−B, computed as A+~B with initial carry 1
  - Select 11: B−A, computed as ~A+B with initial carry 1
- Carry is the carry-out of bit WIDTH−1. For subtraction, Carry=1 means no borrow.
- FSM states and transitions:
  - IDLE: on Start=1, load the A/B shift registers, latch Mode/Select, initialise the carry flop, clear the bit counter, go to RUN.
  - RUN: each cycle the slice combines bit 0 of both shift registers with the carry flop. The result bit shifts into the MSB of the result shift register, operands shift right, carry updates, counter increments. On the cycle with counter = WIDTH−1: copy the completed result into Output, set Carry (Mode=1) or clear it (Mode=0), set Zero, go to DONE.
  - DONE: Done=1 for this one cycle. Start=1 loads a new operation and goes to RUN (back-to-back operation); otherwise go to IDLE.
- Start in RUN is ignored; there is no queueing.
- Operand inputs are don't-care except on the accepting cycle.
- Reset values: state IDLE, Busy=0, Done=0, Output=0, Carry=0, Zero=0, counter=0, carry flop=0.
- Reset asserted mid-RUN abandons the operation. Output and flags return to their reset values, and no Done pulse is issued.

## Timing
- Start accepted at edge k → Busy=1 from edge k through edge k+WIDTH.
- Output, Carry and Zero change at edge k+WIDTH; Done=1 in the cycle that follows.
- Throughput: one operation per WIDTH+1 cycles when Start is held or re-asserted in DONE.
- Busy and Done are never high together.
- Output, Carry and Zero are stable at all times except at the completion edge.
- Counter width is $clog2(WIDTH); it wraps only via reload, never free-running.

## Structure
- Package alu_pkg holds:
  - the op encodings (MODE_LOGIC/MODE_ARITH, the SEL_* constants)
  - the FSM state typedef (IDLE, RUN, DONE)
  - a function returning the initial carry for a given Mode/Select
- Sub-module alu_slice: combinational 1-bit slice.
  - Inputs: Mode, Select, a, b, cin.
  - Outputs: result bit, cout.
  - This is the 1-bit ALU extended with carry in/out.
- Top level alu_serial contains the FSM, counter, shift registers, carry flop and output registers.

## Test plan
All scenarios use WIDTH=8.
- Reset mid-operation: Start with A=8'h12, B=8'h34, then assert Reset at RUN cycle 3 → next edge gives Busy=0, Output=8'h00, Carry=0, Zero=0, and no Done pulse.
- Mode=1, Select=00, A=8'hFF, B=8'h01 → Output=8'h00, Carry=1, Zero=1, Done exactly 9 cycles after the Start edge.
- Mode=1, Select=10, A=8'h05, B=8'h07 → Output=8'hFE, Carry=0 (borrow), Zero=0.
- Mode=1, Select=01, A=8'h03, B=8'h10 → Output=8'h0C, Carry=1.
- Mode=0, Select=11, A=8'hA5, B=8'h0F → Output=8'h55, Carry=0. Also sweep all 8 ops against a reference model on random operands.
- Handshake: Start pulsed during RUN (A=8'h01, B=8'h01) is ignored. Start held high in DONE (Mode=1, Select=00, A=8'h01, B=8'h01) launches the next op immediately, giving Output=8'h02 nine cycles later.
